rr_arb4_onehot: RTL and testbench

- 4-requester round-robin arbiter; sits directly upstream of the 4-to-2 one-hot encoder.
- Drives a registered one-hot grant g[3:0] into encoder inputs x1..x4:
  - g[0]→x1, g[1]→x2, g[2]→x3, g[3]→x4.
- Guarantees the encoder only ever sees all-zero or exactly one hot bit, and holds each grant stable until the owner releases it.

---
 rtl/rr_arb_pkg.sv | 43 ++++
 rtl/rr_prio_mask4.sv | 15 +
 rtl/rr_arb4_onehot.sv | 135 +++++++++++++
 tb/tb_rr_arb4_onehot.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter:
// FSM state encoding, requester count, rotating priority pick and one-hot decode.
package rr_arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // First set request found scanning ptr, ptr+1, ... mod 4, as a one-hot vector.
    function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [3:0] gnt;
        logic       found;
        logic [1:0] idx;
        gnt   = 4'b0000;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end else begin
                found = found;
            end
        end
        return gnt;
    endfunction

    function automatic logic [1:0] onehot2idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_mask4.sv
// Combinational rotate-and-priority-pick: one-hot winner among req starting at ptr.
module rr_prio_mask4
    import rr_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt
);

    // Rotating priority selection
    always_comb begin
        gnt = rr_pick(req, ptr);
    end

endmodule

// File: rtl/rr_arb4_onehot.sv
// Round-robin arbiter driving a registered one-hot grant into a 4-to-2 one-hot encoder.
// Optional forced-release hold timeout enabled by defining ARB_HOLD_TIMEOUT_EN.
module rr_arb4_onehot
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = rr_arb_pkg::N_REQ,
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] g,
    output logic       gnt_valid,
    output logic       timeout
);

    if (N_REQ != 4) begin : g_bad_n_req
        $error("rr_arb4_onehot: N_REQ must be 4 to match the encoder width");
    end
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("rr_arb4_onehot: MAX_HOLD must lie in 2..255");
    end

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] g_q, g_d;
    logic       gv_q, gv_d;
    logic       timeout_q, timeout_d;
    logic [3:0] pick_s;
    logic [1:0] sel_s;
    logic       release_s;
`ifdef ARB_HOLD_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

    rr_prio_mask4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_s)
    );

    // The owner is recovered from the held one-hot grant, so no separate index flop is kept
    always_comb begin
        sel_s     = onehot2idx(g_q);
        release_s = done | ~req[sel_s];
    end

    // Next-state, grant and pointer update
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        g_d       = g_q;
        gv_d      = gv_q;
        timeout_d = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    g_d     = pick_s;
                    gv_d    = 1'b1;
                    state_d = GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
                    hold_cnt_d = 8'd0;
`endif
                end else begin
                    g_d  = 4'b0000;
                    gv_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    g_d     = 4'b0000;
                    gv_d    = 1'b0;
                    ptr_d   = sel_s + 2'd1;
                    state_d = IDLE;
`ifdef ARB_HOLD_TIMEOUT_EN
                end else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
                    // Forced release behaves exactly like a normal one, plus the pulse
                    g_d       = 4'b0000;
                    gv_d      = 1'b0;
                    ptr_d     = sel_s + 2'd1;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`else
                end else begin
                    g_d = g_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                g_d     = 4'b0000;
                gv_d    = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            g_q       <= 4'b0000;
            gv_q      <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            gv_q      <= gv_d;
            timeout_q <= timeout_d;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign g         = g_q;
    assign gnt_valid = gv_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb4_onehot.sv
// Directed self-checking bench for rr_arb4_onehot; timeout checks adapt to ARB_HOLD_TIMEOUT_EN.
module tb_rr_arb4_onehot;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int MH = 4;
`else
    localparam int MH = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic       gnt_valid;
    logic       timeout;

    int total_s;
    int bad_s;

    rr_arb4_onehot #(.N_REQ(4), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .g         (g),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_s++;
        if (got !== exp) begin
            bad_s++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] exp_g);
        chk({tag, ".g"}, {4'b0000, g}, {4'b0000, exp_g});
        chk({tag, ".v"}, {7'd0, gnt_valid}, {7'd0, (exp_g != 4'b0000)});
    endtask

    logic [3:0] seq_s [10];
    logic [1:0] enc_s;

    initial begin
        total_s = 0;
        bad_s   = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        done    = 1'b0;
        #3;
        chk_grant("reset", 4'b0000);
        chk("reset.to", {7'd0, timeout}, 8'd0);
        #9 rst_n = 1'b1;
        tick();
        chk_grant("idle", 4'b0000);

        // single requester, hold, done release
        req = 4'b0100;
        tick();
        chk_grant("grant2", 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_grant("hold2", 4'b0100);
        end
        done = 1'b1;
        tick();
        chk_grant("rel2", 4'b0000);

        // all requesting, done held: order starts at ptr=3
        req  = 4'b1111;
        done = 1'b0;
        tick();
        chk_grant("ptr3", 4'b1000);
        done = 1'b1;
        seq_s = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                  4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_grant($sformatf("rr%0d", i), seq_s[i]);
        end

        // owner 0 withdraws; requester 1 served, then ptr=2 with req=0011 wraps to 0
        done = 1'b0;
        req  = 4'b0010;
        tick();
        chk_grant("wd0", 4'b0000);
        tick();
        chk_grant("grant1", 4'b0010);
        req  = 4'b0011;
        done = 1'b1;
        tick();
        chk_grant("rel1", 4'b0000);
        done = 1'b0;
        tick();
        chk_grant("wrap", 4'b0001);
        enc_s = {g[3] | g[2], g[3] | g[1]};
        chk("wrap.enc", {6'd0, enc_s}, 8'd0);

        // get requester 1 granted, then swap req[1] for req[0] in one cycle
        req  = 4'b0010;
        done = 1'b1;
        tick();
        chk_grant("rel0", 4'b0000);
        done = 1'b0;
        tick();
        chk_grant("grant1b", 4'b0010);
        req = 4'b0001;
        tick();
        chk_grant("swap.gap", 4'b0000);
        tick();
        chk_grant("swap.g0", 4'b0001);

        // asynchronous reset mid-grant
        #2 rst_n = 1'b0;
        #1;
        chk_grant("areset", 4'b0000);
        req = 4'b1010;
        #3 rst_n = 1'b1;
        tick();
        chk_grant("post_rst", 4'b0010);

        // hold with done=0: forced release only when the timeout is compiled in
        req = 4'b0000;
        tick();
        chk_grant("drop1", 4'b0000);
        req = 4'b0001;
        tick();
        chk_grant("th.g", 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_grant("th.hold", 4'b0001);
            chk("th.to0", {7'd0, timeout}, 8'd0);
        end
        tick();
`ifdef ARB_HOLD_TIMEOUT_EN
        chk_grant("th.force", 4'b0000);
        chk("th.to1", {7'd0, timeout}, 8'd1);
        tick();
        chk_grant("th.regrant", 4'b0001);
        chk("th.to_clr", {7'd0, timeout}, 8'd0);
        for (int i = 0; i < 3; i++) tick();
        done = 1'b1;
        tick();
        chk_grant("th.coinc", 4'b0000);
        chk("th.coinc.to", {7'd0, timeout}, 8'd0);
`else
        chk_grant("th.still", 4'b0001);
        chk("th.to_off", {7'd0, timeout}, 8'd0);
        tick();
        chk_grant("th.still2", 4'b0001);
        done = 1'b1;
        tick();
        chk_grant("th.rel", 4'b0000);
        chk("th.rel.to", {7'd0, timeout}, 8'd0);
`endif
        done = 1'b0;
        req  = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total_s, bad_s);
        $finish;
    end

endmodule
